// File: rtl/bus_pkg.sv
// ============================================================================
// bus_pkg : shared bus arbitration types and default watchdog limits
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    ACTIVE  = 2'd2,
    ABORT   = 2'd3
  } arb_state_t;

  // Defaults shared with DmaCTLCI and the bus model
  localparam int BUS_GRANT_WAIT_DEF = 8;
  localparam int BUS_TX_TIMEOUT_DEF = 256;

  function automatic int bus_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_arbiter_rr_picker.sv
// ============================================================================
// rr_picker : combinational round-robin winner selection, scanning upward
//             from the master after the last owner
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module rr_picker #(
  parameter int NUM_MASTERS = 4
) (
  input  logic [NUM_MASTERS-1:0]         i_req,
  input  logic [$clog2(NUM_MASTERS)-1:0] i_last_owner,
  output logic [NUM_MASTERS-1:0]         o_winner,
  output logic                           o_valid
);

  localparam int c_iw = $clog2(NUM_MASTERS);

  logic [c_iw:0]            w_shamt;
  logic [NUM_MASTERS-1:0]   w_rot;
  logic [NUM_MASTERS-1:0]   w_oh_rot;

  // Rotate so that bit 0 is the master right after the last owner
  assign w_shamt = {1'b0, i_last_owner} + (c_iw+1)'(1);
  assign w_rot   = NUM_MASTERS'({i_req, i_req} >> w_shamt);

  always_comb begin
    w_oh_rot = '0;
    o_valid  = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!o_valid && w_rot[k]) begin
        w_oh_rot[k] = 1'b1;
        o_valid     = 1'b1;
      end
    end
  end

  assign o_winner = NUM_MASTERS'(({w_oh_rot, w_oh_rot} << w_shamt) >> NUM_MASTERS);

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// bus_arbiter : round-robin system bus arbiter with grant-wait and
//               transaction watchdogs
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int GRANT_WAIT  = BUS_GRANT_WAIT_DEF,
  parameter int TX_TIMEOUT  = BUS_TX_TIMEOUT_DEF
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_MASTERS-1:0]         bus_request,
  input  logic                           begin_transaction,
  input  logic                           end_transaction_in,
  input  logic                           bus_error_in,
  output logic [NUM_MASTERS-1:0]         bus_grant,
  output logic [$clog2(NUM_MASTERS)-1:0] grant_index,
  output logic                           bus_busy,
  output logic                           end_transaction_out,
  output logic                           bus_error_out
);

  localparam int c_iw = $clog2(NUM_MASTERS);
  localparam int c_cw = $clog2(bus_max(GRANT_WAIT, TX_TIMEOUT) + 1);
  localparam logic [c_cw-1:0] c_grant_wait = c_cw'(GRANT_WAIT);
  localparam logic [c_cw-1:0] c_tx_timeout = c_cw'(TX_TIMEOUT);

  arb_state_t             r_state, w_state_nx;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nx;
  logic [c_iw-1:0]        r_idx, w_idx_nx;
  logic [c_iw-1:0]        r_last, w_last_nx;
  logic [c_cw-1:0]        r_wait, w_wait_nx, w_wait_dec;
  logic [c_cw-1:0]        r_tx, w_tx_nx, w_tx_dec;

  logic [NUM_MASTERS-1:0] w_pick_oh;
  logic                   w_pick_valid;
  logic [c_iw-1:0]        w_pick_idx;
  logic                   w_owner_req;
  logic                   w_release;

  rr_picker #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_picker (
    .i_req        (bus_request),
    .i_last_owner (r_last),
    .o_winner     (w_pick_oh),
    .o_valid      (w_pick_valid)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_pick_oh[i]) w_pick_idx = c_iw'(i);
    end
  end

  assign w_owner_req = |(bus_request & r_grant);
  assign w_wait_dec  = (r_wait == '0) ? '0 : r_wait - c_cw'(1);
  assign w_tx_dec    = (r_tx == '0) ? '0 : r_tx - c_cw'(1);

  // A watchdog fires on the edge where its counter reaches zero, so the
  // grant lives exactly GRANT_WAIT cycles and the abort lands TX_TIMEOUT+1
  // cycles after begin.
  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_idx_nx   = r_idx;
    w_last_nx  = r_last;
    w_wait_nx  = r_wait;
    w_tx_nx    = r_tx;
    w_release  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nx = GRANTED;
          w_grant_nx = w_pick_oh;
          w_idx_nx   = w_pick_idx;
          w_wait_nx  = c_grant_wait;
        end
      end
      GRANTED: begin
        if (begin_transaction) begin
          w_state_nx = ACTIVE;
          w_tx_nx    = c_tx_timeout;
        end else if (!w_owner_req || (w_wait_dec == '0)) begin
          w_release  = 1'b1;
        end else begin
          w_wait_nx  = w_wait_dec;
        end
      end
      ACTIVE: begin
        w_tx_nx = w_tx_dec;
        if (end_transaction_in || bus_error_in) begin
          w_release  = 1'b1;
        end else if (w_tx_dec == '0) begin
          w_state_nx = ABORT;
        end
      end
      ABORT: begin
        w_release = 1'b1;
      end
      default: begin
        w_state_nx = IDLE;
        w_grant_nx = '0;
      end
    endcase
    if (w_release) begin
      w_state_nx = IDLE;
      w_grant_nx = '0;
      w_last_nx  = r_idx;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_idx   <= '0;
      r_last  <= c_iw'(NUM_MASTERS - 1);
      r_wait  <= '0;
      r_tx    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_grant <= w_grant_nx;
      r_idx   <= w_idx_nx;
      r_last  <= w_last_nx;
      r_wait  <= w_wait_nx;
      r_tx    <= w_tx_nx;
    end
  end

  assign bus_grant           = r_grant;
  assign grant_index         = r_idx;
  assign bus_busy            = (r_state != IDLE);
  assign end_transaction_out = (r_state == ABORT);
  assign bus_error_out       = (r_state == ABORT);

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// tb_bus_arbiter : vector table, directed corner sequences and randomized
//                  traffic against a cycle-count reference model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int GW = 8;
  localparam int TX = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] bus_request;
  logic         begin_transaction, end_transaction_in, bus_error_in;
  logic [N-1:0] bus_grant;
  logic [1:0]   grant_index;
  logic         bus_busy, end_transaction_out, bus_error_out;

  always #5 clock = ~clock;

  bus_arbiter #(
    .NUM_MASTERS (N),
    .GRANT_WAIT  (GW),
    .TX_TIMEOUT  (TX)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .bus_request         (bus_request),
    .begin_transaction   (begin_transaction),
    .end_transaction_in  (end_transaction_in),
    .bus_error_in        (bus_error_in),
    .bus_grant           (bus_grant),
    .grant_index         (grant_index),
    .bus_busy            (bus_busy),
    .end_transaction_out (end_transaction_out),
    .bus_error_out       (bus_error_out)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: owner plus cycle ages since grant / since begin
  int m_owner, m_last, m_held, m_age;
  bit m_began, m_abort;

  task automatic m_release();
    m_last  = m_owner;
    m_owner = -1;
    m_began = 0;
    m_abort = 0;
  endtask

  task automatic model_step(input bit rst_n, input logic [N-1:0] req,
                            input bit beg, input bit endi, input bit erri);
    bit found;
    int c;
    if (!rst_n) begin
      m_owner = -1; m_last = N - 1; m_began = 0; m_abort = 0;
      m_held = 0; m_age = 0;
    end else if (m_owner < 0) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!found && req[c]) begin
          found = 1; m_owner = c; m_held = 1; m_began = 0;
        end
      end
    end else if (m_abort) begin
      m_release();
    end else if (!m_began) begin
      if (beg) begin
        m_began = 1; m_age = 1;
      end else if (!req[m_owner] || m_held >= GW) begin
        m_release();
      end else begin
        m_held++;
      end
    end else begin
      if (endi || erri) begin
        m_release();
      end else begin
        m_age++;
        if (m_age == TX + 1) m_abort = 1;
      end
    end
  endtask

  task automatic check_model();
    logic [N-1:0] eg;
    eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    chk("m_grant", bus_grant, eg);
    chk("m_busy", bus_busy, m_owner >= 0);
    chk("m_end_out", end_transaction_out, m_abort);
    chk("m_err_out", bus_error_out, m_abort);
    if (m_owner >= 0) chk("m_index", grant_index, m_owner);
  endtask

  task automatic cycle(input bit rst_n, input logic [N-1:0] req,
                       input bit beg, input bit endi, input bit erri);
    reset              = rst_n;
    bus_request        = req;
    begin_transaction  = beg;
    end_transaction_in = endi;
    bus_error_in       = erri;
    @(posedge clock);
    #1;
    model_step(rst_n, req, beg, endi, erri);
    check_model();
  endtask

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       beg, endi, erri;
    logic [3:0] grant;
    logic       busy;
    logic [1:0] idx;
  } vec_t;

  function automatic vec_t mk(logic rst_n, logic [3:0] req, logic beg, logic endi,
                              logic erri, logic [3:0] g, logic b, logic [1:0] ix);
    vec_t v;
    v.rst_n = rst_n; v.req = req; v.beg = beg; v.endi = endi; v.erri = erri;
    v.grant = g; v.busy = b; v.idx = ix;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int cnt, abort_k;
    logic [N-1:0] rreq;
    bit rbeg, rend, rerr;

    // basic grant: begin 2 cycles after grant, end 5 cycles later
    tbl.push_back(mk(1, 4'b0001, 0, 0, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 4'b0001, 0, 0, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 4'b0001, 1, 0, 0, 4'b0001, 1, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 4'b0001, 0, 0, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 4'b0001, 0, 1, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));
    // round robin over 1011: 0,1,3,0 with an idle cycle between owners
    tbl.push_back(mk(1, 4'b1011, 0, 0, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 4'b1011, 1, 0, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 4'b1011, 0, 0, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 4'b1011, 0, 0, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 4'b1011, 0, 1, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 4'b1011, 0, 0, 0, 4'b0010, 1, 1));
    tbl.push_back(mk(1, 4'b1011, 1, 0, 0, 4'b0010, 1, 1));
    tbl.push_back(mk(1, 4'b1011, 0, 0, 0, 4'b0010, 1, 1));
    tbl.push_back(mk(1, 4'b1011, 0, 0, 0, 4'b0010, 1, 1));
    tbl.push_back(mk(1, 4'b1011, 0, 1, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 4'b1011, 0, 0, 0, 4'b1000, 1, 3));
    tbl.push_back(mk(1, 4'b1011, 1, 0, 0, 4'b1000, 1, 3));
    tbl.push_back(mk(1, 4'b1011, 0, 0, 0, 4'b1000, 1, 3));
    tbl.push_back(mk(1, 4'b1011, 0, 0, 0, 4'b1000, 1, 3));
    tbl.push_back(mk(1, 4'b1011, 0, 1, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 4'b1011, 0, 0, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 4'b1011, 1, 0, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 4'b1011, 0, 0, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 4'b1011, 0, 0, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));

    reset = 1'b0; bus_request = '0;
    begin_transaction = 1'b0; end_transaction_in = 1'b0; bus_error_in = 1'b0;
    #2;
    chk("rst_grant", bus_grant, 0);
    chk("rst_index", grant_index, 0);
    chk("rst_busy", bus_busy, 0);
    chk("rst_end_out", end_transaction_out, 0);
    chk("rst_err_out", bus_error_out, 0);
    model_step(0, '0, 0, 0, 0);
    cycle(0, '0, 0, 0, 0);

    foreach (tbl[i]) begin
      cycle(tbl[i].rst_n, tbl[i].req, tbl[i].beg, tbl[i].endi, tbl[i].erri);
      chk($sformatf("tbl%0d_grant", i), bus_grant, tbl[i].grant);
      chk($sformatf("tbl%0d_busy", i), bus_busy, tbl[i].busy);
      if (tbl[i].busy) chk($sformatf("tbl%0d_index", i), grant_index, tbl[i].idx);
    end

    // grant-wait revoke: master 2 never begins, master 3 waits behind it
    cycle(0, '0, 0, 0, 0);
    cycle(1, 4'b1100, 0, 0, 0);
    cnt = (bus_grant == 4'b0100) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      if (bus_grant != 4'b0100) break;
      cycle(1, 4'b1100, 0, 0, 0);
      if (bus_grant == 4'b0100) cnt++;
    end
    chk("revoke_len", cnt, GW);
    chk("revoke_gap", bus_grant, 4'b0000);
    cycle(1, 4'b1100, 0, 0, 0);
    chk("revoke_next", bus_grant, 4'b1000);
    cycle(1, 4'b1000, 1, 0, 0);
    cycle(1, 4'b1000, 0, 1, 0);
    cycle(1, 4'b0000, 0, 0, 0);

    // transaction abort: master 1 begins and never ends
    cycle(1, 4'b0010, 0, 0, 0);
    cycle(1, 4'b0010, 1, 0, 0);
    abort_k = 0;
    for (int k = 2; k <= 40; k++) begin
      cycle(1, 4'b0010, 0, 0, 0);
      if (end_transaction_out) begin
        abort_k = k;
        chk("abort_err_out", bus_error_out, 1);
        chk("abort_grant_held", bus_grant, 4'b0010);
        break;
      end
    end
    chk("abort_at", abort_k, TX + 1);
    cycle(1, 4'b0000, 0, 0, 0);
    chk("abort_drop_grant", bus_grant, 4'b0000);
    chk("abort_one_cycle", end_transaction_out, 0);
    cycle(1, 4'b0000, 0, 0, 0);

    // end strobe in the cycle the timeout reaches zero
    cycle(1, 4'b0010, 0, 0, 0);
    cycle(1, 4'b0010, 1, 0, 0);
    for (int k = 2; k <= TX; k++) cycle(1, 4'b0010, 0, 0, 0);
    cycle(1, 4'b0010, 0, 1, 0);
    chk("race_no_err", bus_error_out, 0);
    chk("race_no_end_out", end_transaction_out, 0);
    chk("race_released", bus_busy, 0);
    cycle(1, 4'b0000, 0, 0, 0);
    chk("race_still_quiet", bus_error_out, 0);

    // reset in the middle of an active transaction
    cycle(1, 4'b0001, 0, 0, 0);
    cycle(1, 4'b0001, 1, 0, 0);
    cycle(1, 4'b0001, 0, 0, 0);
    chk("pre_reset_busy", bus_busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_grant", bus_grant, 0);
    chk("async_rst_busy", bus_busy, 0);
    chk("async_rst_index", grant_index, 0);
    chk("async_rst_end_out", end_transaction_out, 0);
    chk("async_rst_err_out", bus_error_out, 0);
    cycle(0, '0, 0, 0, 0);
    cycle(1, 4'b0100, 0, 0, 0);
    chk("post_rst_grant", bus_grant, 4'b0100);
    chk("post_rst_index", grant_index, 2);
    cycle(1, 4'b0100, 1, 0, 0);
    cycle(1, 4'b0100, 0, 1, 0);
    cycle(1, 4'b0000, 0, 0, 0);

    // randomized traffic against the model
    rreq = '0;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(7) == 0) rreq[b] = ~rreq[b];
      end
      rbeg = ($urandom_range(3) == 0);
      rend = ($urandom_range(11) == 0);
      rerr = ($urandom_range(23) == 0);
      cycle(($urandom_range(299) != 0), rreq, rbeg, rend, rerr);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares the single system bus between up to NUM_MASTERS bus masters (CPU data port, DmaCTLCI, camera/peripheral DMA engines). It drives the per-master grant (`bus_aquire` at each master), tracks the `begin_transaction` / `end_transaction` framing of the granted master, and enforces two watchdogs:
- **Grant-wait watchdog:** revokes an unused grant.
- **Transaction watchdog:** aborts a hung transaction with `bus_error`.

The block sits between the masters' `bus_request` lines and the shared bus multiplexer, whose select input it provides.

## Interface
- `NUM_MASTERS`, 4: number of requesters, 2..8.
- `GRANT_WAIT`, 8: cycles a granted master has to raise `begin_transaction` before the grant is revoked.
- `TX_TIMEOUT`, 256: cycles allowed between `begin_transaction` and `end_transaction` before abort.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `bus_request`  in  NUM_MASTERS  per-master request, level, held until the master's transaction ends.
- `begin_transaction`  in  1  shared bus begin strobe, one cycle, driven by the granted master.
- `end_transaction_in`  in  1  shared bus end strobe, one cycle, driven by master or slave.
- `bus_error_in`  in  1  slave-signalled error; treated as end of transaction.
- `bus_grant`  out  NUM_MASTERS  one-hot grant, registered.
- `grant_index`  out  $clog2(NUM_MASTERS)  index of the current owner, for the bus mux; valid while `bus_busy`.
- `bus_busy`  out  1  high from grant until release.
- `end_transaction_out`  out  1  one-cycle end strobe issued by the arbiter on timeout abort.
- `bus_error_out`  out  1  one-cycle error strobe, coincident with `end_transaction_out`.

## Operation
States are IDLE, GRANTED, ACTIVE and ABORT.

**IDLE**
- Sample `bus_request`.
- Winner is the first set bit scanning upward from `last_owner+1` (mod NUM_MASTERS).
- `last_owner` resets to NUM_MASTERS-1, so master 0 has first priority after reset.
- If there is a winner: register the one-hot grant, set `grant_index`, load the wait counter with GRANT_WAIT, and go to GRANTED.

**GRANTED**
- `begin_transaction` → load the timeout counter with TX_TIMEOUT and go to ACTIVE.
- Owner drops `bus_request` → release.
- Wait counter reaches 0 → release.
- `begin_transaction` and a request drop in the same cycle: `begin_transaction` wins.

**ACTIVE**
- `end_transaction_in` or `bus_error_in` → release.
- Timeout counter reaches 0 → go to ABORT.
- The counter decrements every cycle.
- Owner dropping `bus_request` in ACTIVE is ignored; the transaction must be framed by an end strobe.

**ABORT**
- Assert `end_transaction_out` and `bus_error_out` for exactly one cycle, then release.

**Release**
- Clear grant and `bus_busy`, set `last_owner` to the owner, return to IDLE.

**Counters**
- Width is $clog2(max(GRANT_WAIT, TX_TIMEOUT)+1).
- Decrement saturates at 0.

**Misc**
- Strobes arriving outside ACTIVE/GRANTED are ignored.
- Requests from non-owners never affect the current owner (no preemption).

## Timing
- Reset values: `bus_grant`=0, `grant_index`=0, `bus_busy`=0, `end_transaction_out`=0, `bus_error_out`=0; state IDLE; counters 0.
- Request to grant: a request visible at edge N gives `bus_grant` and `bus_busy` high after edge N+1 (1-cycle latency).
- End to grant drop: end strobe sampled at edge N gives grant low after edge N+1.
- Back-to-back ownership: the next grant appears no earlier than after edge N+2, so there is always at least one idle cycle with no grant between owners.
- Grant-wait revoke: the grant is high for exactly GRANT_WAIT cycles when `begin_transaction` never arrives.
- Transaction abort: with begin at edge B and no end strobe, the abort strobes are high during cycle B+TX_TIMEOUT+1, and the grant drops one cycle later.
- `end_transaction_in` in the same cycle the timeout hits 0: the normal end wins and no error is signalled.
- Reset mid-transaction: all outputs clear immediately (asynchronously). No abort strobe is emitted.

## Structure
- Shared package `bus_pkg`:
  - state enum `arb_state_t` {IDLE, GRANTED, ACTIVE, ABORT};
  - defaults `BUS_GRANT_WAIT_DEF` and `BUS_TX_TIMEOUT_DEF`, for reuse by DmaCTLCI and the bus model.
- One natural sub-module, `rr_picker`: combinational round-robin priority selection. Inputs are the request vector and the last owner; outputs are the one-hot winner and a valid flag.
- Counters and FSM stay in `bus_arbiter`.

## Test plan
- **Basic grant:** after reset, `bus_request`=4'b0001; master 0 begins 2 cycles after grant and ends 5 cycles later → grant 4'b0001 one cycle after request, `bus_busy` for the whole span, grant cleared one cycle after end.
- **Round robin:** `bus_request`=4'b1011 held, each owner does a 3-cycle transaction → grant order 0, 1, 3, 0, with one idle cycle between grants.
- **Grant-wait revoke:** GRANT_WAIT=8, master 2 requests and never begins → grant high exactly 8 cycles, then master 3 (also requesting) is granted.
- **Timeout abort:** TX_TIMEOUT=16, master 1 begins and never ends → `end_transaction_out` and `bus_error_out` high for one cycle 17 cycles after begin, then grant drops.
- **Same-cycle race:** end strobe coincides with timeout expiry → no `bus_error_out`; release as a normal end.
- **Reset mid-ACTIVE:** assert `reset`=0 → all outputs 0 without waiting for a clock edge. After deassert, `bus_request`=4'b0100 → master 2 granted, since priority restarts at 0 and masters 0/1 are idle.
